osc_phase_accumulator: RTL and testbench
========================================

Name: osc_phase_accumulator

Overview:
- Time-multiplexed per-slot phase accumulator for VOICES*V_OSC oscillator slots. It sits directly downstream of the modulation matrix.
- Each slot's 32-bit phase advances by the pitch increment. The slot's signed phase-modulation offset from the matrix (`modulation`) is added to the phase MSBs to form the sine LUT address.
- Phase state lives in an internal slot-indexed RAM. The block owns the slot sequencing.

Parameters:
- VOICES, 32, voices
- V_OSC, 8, oscillators per voice
- V_WIDTH, 5, voice index width; must equal log2(VOICES)
- O_WIDTH, 3, osc index width; must equal log2(V_OSC)
- PHASE_W, 32, accumulator width
- ADDR_W, 11, sine LUT address width
- MOD_W, 11, modulation input width; must be ≤ ADDR_W

Ports:
- sCLK_XVXOSC  in  1  clock, one slot per cycle
- reset  in  1  synchronous, active-high
- enable  in  1  advance slot sequence when high
- phase_inc  in  PHASE_W  unsigned increment for slot {req_vx,req_ox}, sampled same cycle
- voice_sync  in  1  single-cycle request to zero all phases of a voice
- sync_voice  in  V_WIDTH  voice index for voice_sync
- modulation  in  signed MOD_W  offset for slot {s1_vx,s1_ox}, sampled same cycle
- req_vx  out  V_WIDTH  slot voice whose increment is requested
- req_ox  out  O_WIDTH  slot osc whose increment is requested
- s1_vx  out  V_WIDTH  slot voice in stage 1; modulation must match it
- s1_ox  out  O_WIDTH  slot osc in stage 1; modulation must match it
- lut_addr  out  ADDR_W  sine LUT address
- out_vx  out  V_WIDTH  slot voice tag for lut_addr
- out_ox  out  O_WIDTH  slot osc tag for lut_addr
- out_valid  out  1  lut_addr valid
- busy  out  1  high during RAM clear

Behaviour:
- FSM states: CLEAR and RUN.
- reset (any cycle, including mid-run):
  - state goes to CLEAR; clear counter = 0.
  - req_vx/req_ox = 0; all pipeline valids = 0.
  - lut_addr = 0, out_vx = 0, out_ox = 0, out_valid = 0, busy = 1.
  - req[] = 0, armed[] = 0.
- CLEAR:
  - Writes 0 to phase RAM entry k on cycle k, for k = 0..VOICES*V_OSC-1. This takes 256 cycles at defaults.
  - Ignores enable and voice_sync.
  - After the last write: RUN, busy = 0.
- RUN, slot counter:
  - Slot counter {vx,ox} drives req_vx/req_ox and increments when enable = 1.
  - ox wraps at V_OSC-1 with carry into vx; vx wraps at VOICES-1 to 0.
  - enable = 0: counter holds, no new slot issued, in-flight stages complete normally.
- RUN, stage 0 (issue, cycle N, enable = 1):
  - Read phase RAM[{vx,ox}]; register phase_inc.
  - Register zero flag z = armed_next[vx], defined below.
- RUN, stage 1 (cycle N+1):
  - p = (z ? 0 : ram_rd) + inc, modulo 2^PHASE_W.
  - Write p to RAM[slot]; register p, modulation and tags.
  - s1_vx/s1_ox show this slot.
- RUN, stage 2 (cycle N+2):
  - lut_addr = p[PHASE_W-1 -: ADDR_W] + sign-extended modulation, modulo 2^ADDR_W.
  - out_valid = 1 for exactly one cycle per issued slot; out_vx/out_ox = slot.
- Latency: issue to lut_addr is 2 cycles.
- No RAW hazard: a slot is revisited at the earliest VOICES*V_OSC cycles later. Write-port/read-port conflict is impossible because the indices differ.
- Voice sync:
  - voice_sync sets req[sync_voice].
  - When slot ox = 0 of voice v issues: armed[v] <= req[v]; req[v] <= 0.
  - A same-cycle voice_sync for v keeps req[v] = 1 and also arms, so armed_next includes it.
  - All V_OSC slots of voice v use z = armed[v] (armed_next at ox = 0).
  - armed[v] clears after ox = V_OSC-1 issues.
  - A sync arriving mid-sweep of voice v does not affect the current sweep. It takes effect from the next ox = 0 of v, so all oscs of a voice reset coherently.
  - Repeated syncs before servicing collapse to one.
- Reset phase: a reset slot yields p = inc, not 0.

Test Plan:
- Reset clear: reset 1 cycle, enable = 1 → busy = 1 for 256 cycles, out_valid = 0 throughout. First out_valid is 2 cycles after busy falls, with out_vx = 0, out_ox = 0.
- Accumulation: phase_inc = 0x0020_0000 for all slots, modulation = 0 → slot (0,0) lut_addr = 1, 2, 3 on successive visits. After 2048 visits lut_addr wraps to 0.
- Modulation wrap: phase_inc = 0xFFE0_0000 (first lut_addr 0x7FF), modulation = +2 → lut_addr = 0x001. With modulation = -1024 → lut_addr = 0x3FF.
- Voice sync mid-sweep: assert voice_sync, sync_voice = 3, while issuing (3,4) → slots (3,4..7) keep accumulating. Next sweep of voice 3: all 8 slots output phase_inc MSBs (p = inc). Other voices are unaffected.
- enable gaps: toggle enable pseudo-randomly → out_valid count equals issued count; sequence order, out tags and per-slot phase are identical to a gapless run.
- Reset mid-run: reset during stage-1 activity → out_valid = 0 next cycle, full 256-cycle CLEAR. Post-clear phases restart from 0 and pending syncs are discarded.

Source files
------------

// File: rtl/osc_phase_accumulator.sv
// Time-multiplexed per-slot phase accumulator feeding the sine LUT.
// One oscillator slot {vx,ox} is issued per cycle. The slot's 32-bit phase,
// held in an internal slot-indexed RAM, advances by phase_inc. The top
// ADDR_W bits plus the signed modulation offset form the LUT address.
// Ports:
//   sCLK_XVXOSC  clock, one slot per cycle
//   reset        synchronous active-high reset (starts a RAM clear)
//   enable       advance the slot sequence when high
//   phase_inc    increment for slot {req_vx,req_ox}, sampled same cycle
//   voice_sync   request to zero all phases of voice sync_voice
//   sync_voice   voice index for voice_sync
//   modulation   signed offset for slot {s1_vx,s1_ox}, sampled same cycle
//   req_vx/ox    slot whose increment is requested (issue stage)
//   s1_vx/ox     slot in stage 1 (modulation must match it)
//   lut_addr     sine LUT address, tagged by out_vx/out_ox, qualified by out_valid
//   busy         high while the phase RAM is being cleared
module osc_phase_accumulator #(
    parameter int unsigned VOICES  = 32,
    parameter int unsigned V_OSC   = 8,
    parameter int unsigned V_WIDTH = 5,
    parameter int unsigned O_WIDTH = 3,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MOD_W   = 11
) (
    input  logic                      sCLK_XVXOSC,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PHASE_W-1:0]        phase_inc,
    input  logic                      voice_sync,
    input  logic [V_WIDTH-1:0]        sync_voice,
    input  logic signed [MOD_W-1:0]   modulation,
    output logic [V_WIDTH-1:0]        req_vx,
    output logic [O_WIDTH-1:0]        req_ox,
    output logic [V_WIDTH-1:0]        s1_vx,
    output logic [O_WIDTH-1:0]        s1_ox,
    output logic [ADDR_W-1:0]         lut_addr,
    output logic [V_WIDTH-1:0]        out_vx,
    output logic [O_WIDTH-1:0]        out_ox,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int unsigned SLOTS  = VOICES * V_OSC;
    localparam int unsigned SLOT_W = V_WIDTH + O_WIDTH;
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [O_WIDTH-1:0] LAST_OX   = O_WIDTH'(V_OSC - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SLOT_W-1:0]    clr_q, clr_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [VOICES-1:0]    req_q, req_d;
    logic [VOICES-1:0]    armed_q, armed_d;
    logic                 busy_q, busy_d;

    // Stage 1 registers (slot read from RAM, increment, zero flag)
    logic                 s1_vld_q, s1_vld_d;
    logic [SLOT_W-1:0]    s1_slot_q, s1_slot_d;
    logic [PHASE_W-1:0]   s1_inc_q, s1_inc_d;
    logic                 s1_z_q, s1_z_d;
    logic [PHASE_W-1:0]   s1_rd_q;

    // Stage 2 (output) registers
    logic                 out_vld_q, out_vld_d;
    logic [SLOT_W-1:0]    out_slot_q, out_slot_d;
    logic [ADDR_W-1:0]    lut_q, lut_d;

    logic [PHASE_W-1:0]   ram_q [SLOTS];

    logic                 issue;
    logic [V_WIDTH-1:0]   cur_vx;
    logic [O_WIDTH-1:0]   cur_ox;
    logic                 sync_hit;
    logic                 zero_flag;
    logic [PHASE_W-1:0]   phase_nx;
    logic [ADDR_W-1:0]    mod_ext;
    logic                 ram_we;
    logic [SLOT_W-1:0]    ram_wa;
    logic [PHASE_W-1:0]   ram_wd;

    // Issue-stage decode and stage-1 datapath
    always_comb begin
        issue     = (state_q == ST_RUN) && enable;
        cur_vx    = slot_q[SLOT_W-1 -: V_WIDTH];
        cur_ox    = slot_q[O_WIDTH-1:0];
        sync_hit  = voice_sync && (sync_voice == cur_vx);
        // At ox = 0 the voice is (re)armed from its pending request, including
        // a request arriving this very cycle; later oscs reuse the armed bit.
        zero_flag = (cur_ox == '0) ? (req_q[cur_vx] | sync_hit) : armed_q[cur_vx];
        phase_nx  = (s1_z_q ? '0 : s1_rd_q) + s1_inc_q;
        mod_ext   = ADDR_W'(modulation);
        ram_we    = !reset && ((state_q == ST_CLEAR) || s1_vld_q);
        ram_wa    = (state_q == ST_CLEAR) ? clr_q : s1_slot_q;
        ram_wd    = (state_q == ST_CLEAR) ? '0 : phase_nx;
    end

    // Next-state and pipeline control
    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        slot_d     = slot_q;
        req_d      = req_q;
        armed_d    = armed_q;
        busy_d     = busy_q;
        s1_vld_d   = 1'b0;
        s1_slot_d  = s1_slot_q;
        s1_inc_d   = s1_inc_q;
        s1_z_d     = s1_z_q;
        out_vld_d  = 1'b0;
        out_slot_d = out_slot_q;
        lut_d      = lut_q;

        unique case (state_q)
            ST_CLEAR: begin
                clr_d = clr_q + SLOT_W'(1);
                if (clr_q == LAST_SLOT) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    slot_d    = slot_q + SLOT_W'(1);
                    s1_vld_d  = 1'b1;
                    s1_slot_d = slot_q;
                    s1_inc_d  = phase_inc;
                    s1_z_d    = zero_flag;
                    if (cur_ox == '0) begin
                        armed_d[cur_vx] = req_q[cur_vx] | sync_hit;
                        req_d[cur_vx]   = 1'b0;
                    end
                    if (cur_ox == LAST_OX) begin
                        armed_d[cur_vx] = 1'b0;
                    end
                end
                // A sync landing on the voice's ox = 0 stays pending as well
                if (voice_sync) begin
                    req_d[sync_voice] = 1'b1;
                end
                if (s1_vld_q) begin
                    out_vld_d  = 1'b1;
                    out_slot_d = s1_slot_q;
                    lut_d      = phase_nx[PHASE_W-1 -: ADDR_W] + mod_ext;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_q      <= '0;
            slot_q     <= '0;
            req_q      <= '0;
            armed_q    <= '0;
            busy_q     <= 1'b1;
            s1_vld_q   <= 1'b0;
            s1_slot_q  <= '0;
            s1_inc_q   <= '0;
            s1_z_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_slot_q <= '0;
            lut_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            slot_q     <= slot_d;
            req_q      <= req_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            s1_vld_q   <= s1_vld_d;
            s1_slot_q  <= s1_slot_d;
            s1_inc_q   <= s1_inc_d;
            s1_z_q     <= s1_z_d;
            out_vld_q  <= out_vld_d;
            out_slot_q <= out_slot_d;
            lut_q      <= lut_d;
        end
    end

    // Phase RAM: write port from clear/stage 1, synchronous read at issue.
    // Read and write slots always differ, so no bypass is needed.
    always_ff @(posedge sCLK_XVXOSC) begin
        if (ram_we) begin
            ram_q[ram_wa] <= ram_wd;
        end
        if (issue) begin
            s1_rd_q <= ram_q[slot_q];
        end
    end

    assign req_vx    = slot_q[SLOT_W-1 -: V_WIDTH];
    assign req_ox    = slot_q[O_WIDTH-1:0];
    assign s1_vx     = s1_slot_q[SLOT_W-1 -: V_WIDTH];
    assign s1_ox     = s1_slot_q[O_WIDTH-1:0];
    assign lut_addr  = lut_q;
    assign out_vx    = out_slot_q[SLOT_W-1 -: V_WIDTH];
    assign out_ox    = out_slot_q[O_WIDTH-1:0];
    assign out_valid = out_vld_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_osc_phase_accumulator.sv
// Self-checking bench for osc_phase_accumulator: a behavioural slot model
// pushes expected LUT outputs into a scoreboard at issue time, popped and
// compared when they fall due two cycles later.
module tb_osc_phase_accumulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [31:0]        phase_inc;
    logic               voice_sync;
    logic [4:0]         sync_voice;
    logic signed [10:0] modulation;
    logic [4:0]         req_vx, s1_vx, out_vx;
    logic [2:0]         req_ox, s1_ox, out_ox;
    logic [10:0]        lut_addr;
    logic               out_valid;
    logic               busy;

    always #5 clk = ~clk;

    osc_phase_accumulator dut (
        .sCLK_XVXOSC (clk),
        .reset       (reset),
        .enable      (enable),
        .phase_inc   (phase_inc),
        .voice_sync  (voice_sync),
        .sync_voice  (sync_voice),
        .modulation  (modulation),
        .req_vx      (req_vx),
        .req_ox      (req_ox),
        .s1_vx       (s1_vx),
        .s1_ox       (s1_ox),
        .lut_addr    (lut_addr),
        .out_vx      (out_vx),
        .out_ox      (out_ox),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    typedef struct {
        int          due;
        logic [10:0] lut;
        int          vx;
        int          ox;
    } exp_t;

    exp_t        sbq[$];
    logic [10:0] q00[$];
    logic [31:0] inc_tab [256];
    logic [31:0] m_ph [256];
    bit   [31:0] m_req;
    bit   [31:0] m_armed;
    int          m_slot;
    bit          m_run;
    int          m_clr;
    int          cyc = 0;
    int          mod_val;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge
    task automatic cycle(input bit en, input bit sync, input int sv, input bit rst);
        int          v;
        int          o;
        bit          z;
        logic [31:0] p;
        exp_t        e;
        reset      = rst;
        enable     = en;
        voice_sync = sync;
        sync_voice = 5'(sv);
        phase_inc  = inc_tab[m_slot];
        modulation = 11'(mod_val);
        if (rst) begin
            sbq.delete();
            m_run = 0; m_clr = 0; m_slot = 0; m_req = '0; m_armed = '0;
            for (int i = 0; i < 256; i++) m_ph[i] = '0;
        end else if (!m_run) begin
            if (m_clr == 255) m_run = 1;
            else m_clr++;
        end else begin
            if (en) begin
                v = m_slot / 8;
                o = m_slot % 8;
                if (o == 0) z = m_req[v] | (sync && sv == v);
                else        z = m_armed[v];
                p = (z ? 32'h0 : m_ph[m_slot]) + inc_tab[m_slot];
                m_ph[m_slot] = p;
                e.due = cyc + 2;
                e.lut = p[31:21] + 11'(mod_val);
                e.vx  = v;
                e.ox  = o;
                sbq.push_back(e);
                if (o == 0) begin
                    m_armed[v] = m_req[v] | (sync && sv == v);
                    m_req[v]   = 1'b0;
                end
                if (o == 7) m_armed[v] = 1'b0;
                m_slot = (m_slot + 1) % 256;
            end
            if (sync) m_req[sv] = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("busy", 32'(busy), 32'(!m_run));
        chk("req_slot", 32'({req_vx, req_ox}), 32'(m_slot));
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("out_valid_hi", 32'(out_valid), 32'd1);
            chk("lut_addr", 32'(lut_addr), 32'(e.lut));
            chk("out_vx", 32'(out_vx), 32'(e.vx));
            chk("out_ox", 32'(out_ox), 32'(e.ox));
            if (e.vx == 0 && e.ox == 0) q00.push_back(lut_addr);
        end else begin
            chk("out_valid_lo", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic run(input int n, input bit en);
        for (int k = 0; k < n; k++) cycle(en, 1'b0, 0, 1'b0);
    endtask

    task automatic run_to(input int s);
        for (int k = 0; k < 512 && m_slot != s; k++) cycle(1'b1, 1'b0, 0, 1'b0);
        chk("run_to_slot", 32'(m_slot), 32'(s));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; voice_sync = 1'b0; sync_voice = '0;
        phase_inc = '0; modulation = '0;
        m_slot = 0; m_run = 0; m_clr = 0; m_req = '0; m_armed = '0;
        for (int i = 0; i < 256; i++) begin
            inc_tab[i] = 32'h0020_0000;
            m_ph[i]    = '0;
        end
        mod_val = 0;

        // Reset and clear; syncs during clear are ignored
        cycle(1'b1, 1'b0, 0, 1'b1);
        chk("rst_lut", 32'(lut_addr), 32'd0);
        chk("rst_out_vx", 32'(out_vx), 32'd0);
        chk("rst_out_ox", 32'(out_ox), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 256; i++) cycle(1'b1, (i == 100), 3, 1'b0);
        chk("clear_done", 32'(busy), 32'd0);

        // Accumulation: slot (0,0) visits give 1, 2, 3
        run(770, 1'b1);
        chk("acc_visits", 32'(q00.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++)
            if (i < q00.size()) chk("acc_slot00", 32'(q00[i]), 32'(i + 1));

        // Modulation wrap upward
        for (int i = 0; i < 256; i++) inc_tab[i] = 32'hFFE0_0000;
        mod_val = 2;
        cycle(1'b1, 1'b0, 0, 1'b1);
        run(258, 1'b1);
        chk("modp2_valid", 32'(out_valid), 32'd1);
        chk("modp2_lut", 32'(lut_addr), 32'h001);
        chk("modp2_tag", 32'({out_vx, out_ox}), 32'd0);

        // Modulation wrap downward
        mod_val = -1024;
        cycle(1'b1, 1'b0, 0, 1'b1);
        run(258, 1'b1);
        chk("modm1024_lut", 32'(lut_addr), 32'h3FF);

        // Varied increments, mid-sweep and same-cycle syncs
        for (int i = 0; i < 256; i++)
            inc_tab[i] = (i % 16 == 5) ? 32'h4000_0000 : $urandom;
        mod_val = -300;
        cycle(1'b1, 1'b0, 0, 1'b1);
        run(256, 1'b1);
        run_to(28);
        cycle(1'b1, 1'b1, 3, 1'b0);      // sync voice 3 while issuing (3,4)
        run_to(80);
        cycle(1'b1, 1'b1, 10, 1'b0);     // sync voice 10 at its own ox = 0
        run_to(100);
        cycle(1'b1, 1'b1, 7, 1'b0);      // repeated syncs collapse
        cycle(1'b0, 1'b1, 7, 1'b0);
        run(600, 1'b1);

        // Enable gaps with occasional syncs
        for (int i = 0; i < 1500; i++)
            cycle(($urandom % 10) < 7, ($urandom % 50) == 0, int'($urandom % 32), 1'b0);
        run(4, 1'b0);
        chk("gaps_drained", 32'(sbq.size()), 32'd0);

        // Reset mid-run with stage 1 busy and a sync pending
        run_to(160);
        cycle(1'b1, 1'b1, 5, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        run(256, 1'b1);
        run(600, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
